// File: rtl/isa_exec_ctrl.sv
// rtl/isa_exec_ctrl.sv - execute-stage sequencer for the ISA unit bank
//
// Purpose: accepts one decoded instruction at a time, enables exactly one ISA
// unit, routes that unit's register-file read request to the shared port,
// waits for the unit's finished flag and commits the next ip: the unit's
// ip override if it gave one, else ip + INSN_BYTES. An illegal opcode or a
// unit that never finishes halts the core with a sticky fault.
//
// Ports:
//   clk_i            clock, all logic on posedge
//   rst_i            synchronous active-high reset
//   insn_valid_i     decoded instruction present
//   insn_opcode_i    unit select (opcode N -> unit N)
//   insn_ready_o     instruction accepted this cycle (IDLE)
//   unit_en_o        one-hot unit enable, registered
//   unit_finished_i  per-unit finished flag
//   unit_reg_id_i    per-unit reg id, unit k at [4k+3:4k]
//   unit_reg_re_i    per-unit reg read enable
//   unit_ip_set_i    per-unit ip override strobe
//   unit_ip_val_i    per-unit ip value, unit k at [64k+63:64k]
//   reg_id_o         register-file read id from the selected unit
//   reg_re_o         register-file read enable from the selected unit
//   ip_o             committed instruction pointer
//   busy_o           controller not idle
//   fault_o          sticky fault, core halted
//   fault_code_o     0 none, 1 illegal opcode, 2 watchdog timeout

module isa_exec_ctrl #(
  parameter int          NUM_UNITS  = 4,
  parameter int          OPC_W      = 4,
  parameter int          INSN_BYTES = 2,
  parameter int          TIMEOUT    = 15,
  parameter logic [63:0] RESET_IP   = 64'h0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    insn_valid_i,
  input  logic [OPC_W-1:0]        insn_opcode_i,
  output logic                    insn_ready_o,
  output logic [NUM_UNITS-1:0]    unit_en_o,
  input  logic [NUM_UNITS-1:0]    unit_finished_i,
  input  logic [4*NUM_UNITS-1:0]  unit_reg_id_i,
  input  logic [NUM_UNITS-1:0]    unit_reg_re_i,
  input  logic [NUM_UNITS-1:0]    unit_ip_set_i,
  input  logic [64*NUM_UNITS-1:0] unit_ip_val_i,
  output logic [3:0]              reg_id_o,
  output logic                    reg_re_o,
  output logic [63:0]             ip_o,
  output logic                    busy_o,
  output logic                    fault_o,
  output logic [1:0]              fault_code_o
);

  localparam int SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  state_t               state_q;
  logic [SEL_W-1:0]     sel_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_UNITS-1:0] unit_en_q;
  logic [63:0]          ip_q;
  logic [63:0]          pend_ip_q;
  logic                 pend_q;
  logic                 fault_q;
  logic [1:0]           fault_code_q;

  // Signals of the selected unit; everything from other units is dropped here.
  logic                 sel_finished;
  logic                 sel_ip_set;
  logic [63:0]          sel_ip_val;
  logic [3:0]           sel_reg_id;
  logic                 sel_reg_re;
  logic [NUM_UNITS-1:0] opc_onehot;
  logic                 opc_legal;

  always_comb begin
    sel_finished = 1'b0;
    sel_ip_set   = 1'b0;
    sel_ip_val   = 64'h0;
    sel_reg_id   = 4'h0;
    sel_reg_re   = 1'b0;
    opc_onehot   = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (sel_q == k[SEL_W-1:0]) begin
        sel_finished = unit_finished_i[k];
        sel_ip_set   = unit_ip_set_i[k];
        sel_ip_val   = unit_ip_val_i[64*k +: 64];
        sel_reg_id   = unit_reg_id_i[4*k +: 4];
        sel_reg_re   = unit_reg_re_i[k];
      end
      opc_onehot[k] = (insn_opcode_i == k[OPC_W-1:0]);
    end
  end

  assign opc_legal = ({{(32-OPC_W){1'b0}}, insn_opcode_i} < 32'(NUM_UNITS));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      cnt_q        <= '0;
      unit_en_q    <= '0;
      ip_q         <= RESET_IP;
      pend_ip_q    <= 64'h0;
      pend_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (insn_valid_i) begin
            if (opc_legal) begin
              sel_q     <= insn_opcode_i[SEL_W-1:0];
              unit_en_q <= opc_onehot;
              cnt_q     <= '0;
              state_q   <= ST_EXEC;
            end else begin
              fault_q      <= 1'b1;
              fault_code_q <= 2'd1;
              state_q      <= ST_HALT;
            end
          end
        end
        ST_EXEC: begin
          if (sel_finished) begin
            // A same-cycle override beats an earlier latched one.
            if (sel_ip_set)  ip_q <= sel_ip_val;
            else if (pend_q) ip_q <= pend_ip_q;
            else             ip_q <= ip_q + 64'(INSN_BYTES);
            pend_q    <= 1'b0;
            unit_en_q <= '0;
            state_q   <= ST_RELEASE;
          end else begin
            if (sel_ip_set) begin
              pend_ip_q <= sel_ip_val;
              pend_q    <= 1'b1;
            end
            if (cnt_q == CNT_W'(TIMEOUT-1)) begin
              unit_en_q    <= '0;
              fault_q      <= 1'b1;
              fault_code_q <= 2'd2;
              state_q      <= ST_HALT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          // One idle cycle so the unit sees its enable fall and self-clears.
          state_q <= ST_IDLE;
        end
        default: begin
          unit_en_q <= '0;
        end
      endcase
    end
  end

  assign insn_ready_o = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign unit_en_o    = unit_en_q;
  assign ip_o         = ip_q;
  assign fault_o      = fault_q;
  assign fault_code_o = fault_code_q;
  assign reg_id_o     = (state_q == ST_EXEC) ? sel_reg_id : 4'h0;
  assign reg_re_o     = (state_q == ST_EXEC) ? sel_reg_re : 1'b0;

endmodule

// File: tb/tb_isa_exec_ctrl.sv
// tb/tb_isa_exec_ctrl.sv - directed self-checking bench for isa_exec_ctrl
//
// Purpose: directed vectors with hand-computed expectations covering normal
// issue, branch override, pending override, watchdog, illegal opcode, reset
// during execute and ip wrap.
// Ports: none (top-level bench).

module tb_isa_exec_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         insn_valid;
  logic [3:0]   insn_opcode;
  logic         insn_ready;
  logic [3:0]   unit_en;
  logic [3:0]   unit_finished;
  logic [15:0]  unit_reg_id;
  logic [3:0]   unit_reg_re;
  logic [3:0]   unit_ip_set;
  logic [255:0] unit_ip_val;
  logic [3:0]   reg_id;
  logic         reg_re;
  logic [63:0]  ip;
  logic         busy;
  logic         fault;
  logic [1:0]   fault_code;

  int n_cmp = 0;
  int n_err = 0;

  isa_exec_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .insn_valid_i    (insn_valid),
    .insn_opcode_i   (insn_opcode),
    .insn_ready_o    (insn_ready),
    .unit_en_o       (unit_en),
    .unit_finished_i (unit_finished),
    .unit_reg_id_i   (unit_reg_id),
    .unit_reg_re_i   (unit_reg_re),
    .unit_ip_set_i   (unit_ip_set),
    .unit_ip_val_i   (unit_ip_val),
    .reg_id_o        (reg_id),
    .reg_re_o        (reg_re),
    .ip_o            (ip),
    .busy_o          (busy),
    .fault_o         (fault),
    .fault_code_o    (fault_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_units();
    unit_finished = '0;
    unit_reg_id   = '0;
    unit_reg_re   = '0;
    unit_ip_set   = '0;
    unit_ip_val   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    insn_valid = 1'b0;
    clear_units();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Issue opcode from IDLE; afterwards the DUT is in its first EXEC cycle.
  task automatic issue(input logic [3:0] opc);
    insn_valid  = 1'b1;
    insn_opcode = opc;
    tick();
    insn_valid  = 1'b0;
  endtask

  initial begin
    insn_opcode = '0;
    do_reset();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_en", unit_en, 0);
    check("rst_ip", ip, 0);
    check("rst_fault", fault, 0);
    check("rst_code", fault_code, 0);
    check("rst_ready", insn_ready, 1);
    check("rst_re", reg_re, 0);

    // 1. plain instruction on unit 1, finishes in its second EXEC cycle
    issue(4'd1);
    check("t1_en_c1", unit_en, 4'b0010);
    check("t1_ready_c1", insn_ready, 0);
    check("t1_busy_c1", busy, 1);
    tick();
    check("t1_en_c2", unit_en, 4'b0010);
    unit_finished[1] = 1'b1;
    tick();
    unit_finished = '0;
    check("t1_en_rel", unit_en, 0);
    check("t1_ip", ip, 64'h2);
    check("t1_ready_rel", insn_ready, 0);
    check("t1_busy_rel", busy, 1);
    tick();
    check("t1_ready_idle", insn_ready, 1);
    check("t1_busy_idle", busy, 0);

    // 2. branch on unit 0 with reg read, noise on unit 1 read port
    issue(4'd0);
    unit_reg_id[3:0] = 4'd5;
    unit_reg_re[0]   = 1'b1;
    unit_reg_id[7:4] = 4'd9;
    unit_reg_re[1]   = 1'b1;
    #1;
    check("t2_reg_id", reg_id, 4'd5);
    check("t2_reg_re", reg_re, 1);
    tick();
    clear_units();
    unit_ip_set[0]     = 1'b1;
    unit_ip_val[63:0]  = 64'h1000;
    unit_finished[0]   = 1'b1;
    #1;
    check("t2_reg_re_off", reg_re, 0);
    tick();
    clear_units();
    check("t2_ip", ip, 64'h1000);
    check("t2_en", unit_en, 0);
    check("t2_reg_re_rel", reg_re, 0);
    tick();

    // 3. ip_set one cycle before finished goes through the pending latch
    issue(4'd2);
    unit_ip_set[2]        = 1'b1;
    unit_ip_val[191:128]  = 64'h40;
    tick();
    unit_ip_set           = '0;
    unit_ip_val[191:128]  = 64'hDEAD;
    unit_finished[2]      = 1'b1;
    tick();
    clear_units();
    check("t3_ip", ip, 64'h40);
    tick();
    check("t3_ready", insn_ready, 1);

    // 5. watchdog on unit 3 with noise on the other units
    issue(4'd3);
    for (int i = 1; i <= 14; i++) begin
      unit_finished[2:0]   = 3'($urandom_range(0, 7));
      unit_ip_set[2:0]     = 3'($urandom_range(0, 7));
      unit_ip_val[127:0]   = {$urandom, $urandom, $urandom, $urandom};
      tick();
      check($sformatf("t5_en_c%0d", i + 1), unit_en, 4'b1000);
      check($sformatf("t5_fault_c%0d", i + 1), fault, 0);
    end
    tick();
    clear_units();
    check("t5_en_wd", unit_en, 0);
    check("t5_fault", fault, 1);
    check("t5_code", fault_code, 2);
    check("t5_ip", ip, 64'h40);
    check("t5_ready", insn_ready, 0);
    check("t5_busy", busy, 1);
    issue(4'd1);
    check("t5_en_held", unit_en, 0);
    check("t5_code_held", fault_code, 2);

    // 4. illegal opcode
    do_reset();
    issue(4'd4);
    check("t4_fault", fault, 1);
    check("t4_code", fault_code, 1);
    check("t4_en", unit_en, 0);
    check("t4_ready", insn_ready, 0);
    insn_valid  = 1'b1;
    insn_opcode = 4'd0;
    tick();
    tick();
    insn_valid  = 1'b0;
    check("t4_en_held", unit_en, 0);
    check("t4_ready_held", insn_ready, 0);
    check("t4_fault_held", fault, 1);
    check("t4_code_held", fault_code, 1);
    do_reset();
    check("t4_fault_clr", fault, 0);
    check("t4_ready_clr", insn_ready, 1);

    // 6. reset during EXEC; finished in the same cycle must not commit
    issue(4'd1);
    unit_finished[1] = 1'b1;
    tick();
    unit_finished = '0;
    tick();
    check("t6_pre_ip", ip, 64'h2);
    issue(4'd1);
    check("t6_en_exec", unit_en, 4'b0010);
    rst = 1'b1;
    unit_finished[1] = 1'b1;
    tick();
    rst = 1'b0;
    unit_finished = '0;
    check("t6_en", unit_en, 0);
    check("t6_ip", ip, 64'h0);
    check("t6_busy", busy, 0);
    check("t6_ready", insn_ready, 1);

    // ip wrap: branch to all ones, then a plain instruction wraps to 1
    issue(4'd0);
    unit_ip_set[0]    = 1'b1;
    unit_ip_val[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
    unit_finished[0]  = 1'b1;
    tick();
    clear_units();
    check("wrap_pre", ip, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    issue(4'd1);
    unit_finished[1] = 1'b1;
    tick();
    clear_units();
    check("wrap_ip", ip, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
